pattern_history_table: RTL and testbench

//  Parametrised branch pattern history table: 2^INDEX_BITS saturating counters of CTR_BITS each.

---
 rtl/pht_pkg.sv | 29 ++
 rtl/sat_ctr_next.sv | 23 ++
 rtl/pattern_history_table.sv | 73 +++++++
 tb/tb_pattern_history_table.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pht_pkg.sv
// Shared counter helpers for the pattern history table: reset value, saturation limit
// and the reference saturating update for the default counter width.
package pht_pkg;

  localparam int PHT_CTR_BITS = 2;

  typedef logic [PHT_CTR_BITS-1:0] ctr_t;

  // Weakly not-taken: all ones below the MSB.
  function automatic int ctr_init_val(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int ctr_max_val(input int bits);
    return (1 << bits) - 1;
  endfunction

  function automatic ctr_t sat_next(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != '1) res = ctr + 1'b1;
    end else if (ctr != '0) begin
      res = ctr - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_ctr_next.sv
// Combinational saturating increment/decrement of one CTR_BITS counter.
module sat_ctr_next
  import pht_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                taken,
  output logic [CTR_BITS-1:0] next
);

  localparam logic [CTR_BITS-1:0] MAX = '1;

  always_comb begin
    next = ctr;
    if (taken) begin
      if (ctr != MAX) next = ctr + 1'b1;
    end else if (ctr != '0) begin
      next = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/pattern_history_table.sv
// Branch pattern history table of saturating counters with registered predictions and
// update-to-predict forwarding. Define PHT_GSHARE_EN to XOR a global history into the index.
module pattern_history_table
  import pht_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pred_valid,
  input  logic [INDEX_BITS-1:0] pred_index,
  output logic [INDEX_BITS-1:0] pred_hidx,
  output logic                  pred_out_v,
  output logic                  pred_taken,
  output logic [CTR_BITS-1:0]   pred_ctr,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init_val(CTR_BITS));

  // Valid semantics: pred_valid/upd_valid are single-cycle strobes accepted on every
  // rising edge (no ready); pred_out_v is pred_valid delayed one cycle.
  logic [CTR_BITS-1:0]   entries [DEPTH];
  logic [INDEX_BITS-1:0] hidx;
  logic [CTR_BITS-1:0]   upd_next;
  logic [CTR_BITS-1:0]   rd_ctr;

`ifdef PHT_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  assign hidx = pred_index ^ INDEX_BITS'(ghr);

  always_ff @(posedge clk) begin
    if (reset) ghr <= '0;
    else if (upd_valid) ghr <= GHR_BITS'({ghr, upd_taken});
  end
`else
  assign hidx = pred_index;
`endif

  sat_ctr_next #(.CTR_BITS(CTR_BITS)) u_sat (
    .ctr   (entries[upd_index]),
    .taken (upd_taken),
    .next  (upd_next)
  );

  // A same-cycle update to the predicted entry is reported post-update.
  assign rd_ctr = (upd_valid && (upd_index == hidx)) ? upd_next : entries[hidx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= CTR_INIT;
      pred_out_v <= 1'b0;
      pred_taken <= 1'b0;
      pred_ctr   <= '0;
      pred_hidx  <= '0;
    end else begin
      if (upd_valid) entries[upd_index] <= upd_next;
      pred_out_v <= pred_valid;
      if (pred_valid) begin
        pred_hidx  <= hidx;
        pred_ctr   <= rd_ctr;
        pred_taken <= rd_ctr[CTR_BITS-1];
      end
    end
  end

endmodule

// File: tb/tb_pattern_history_table.sv
// Scoreboard bench for pattern_history_table (default parameters; honours PHT_GSHARE_EN).
module tb_pattern_history_table;

  localparam int IB = 4;
  localparam int CB = 2;
  localparam int GB = 4;
  localparam int DEPTH = 1 << IB;
  localparam int W = IB + 1 + CB;

  logic          clk = 1'b0;
  logic          reset;
  logic          pred_valid;
  logic [IB-1:0] pred_index;
  logic [IB-1:0] pred_hidx;
  logic          pred_out_v;
  logic          pred_taken;
  logic [CB-1:0] pred_ctr;
  logic          upd_valid;
  logic [IB-1:0] upd_index;
  logic          upd_taken;

  pattern_history_table #(.INDEX_BITS(IB), .CTR_BITS(CB), .GHR_BITS(GB)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_index(pred_index),
    .pred_hidx(pred_hidx), .pred_out_v(pred_out_v),
    .pred_taken(pred_taken), .pred_ctr(pred_ctr),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  int model [DEPTH];
  int ghr_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_next(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  function automatic int model_hash(input int idx);
`ifdef PHT_GSHARE_EN
    return idx ^ ghr_m;
`else
    return idx;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 1;
    ghr_m = 0;
  endtask

  // One clock: drive inputs, predict into the queue, advance model, check outputs.
  task automatic cycle(input bit pv, input int pidx, input bit uv, input int uidx, input bit ut);
    int h;
    int c;
    logic [W-1:0] e;
    logic [W-1:0] got;
    pred_valid = pv; pred_index = IB'(pidx);
    upd_valid = uv; upd_index = IB'(uidx); upd_taken = ut;
    if (pv) begin
      h = model_hash(pidx);
      c = (uv && uidx == h) ? model_next(model[h], ut) : model[h];
      e = {IB'(h), 1'(c >> 1), CB'(c)};
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (uv) begin
      model[uidx] = model_next(model[uidx], ut);
      ghr_m = ((ghr_m << 1) | int'(ut)) & ((1 << GB) - 1);
    end
    #1;
    pred_valid = 0; upd_valid = 0;
    check("pred_out_v", 32'(pred_out_v), 32'(pv));
    if (pv) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        got = {pred_hidx, pred_taken, pred_ctr};
        check("pred_result", 32'(got), 32'(e));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1; pred_valid = 1; pred_index = 4'h3; upd_valid = 1; upd_index = 4'h3; upd_taken = 1;
    @(posedge clk); #1;
    check("rst_out_v", 32'(pred_out_v), 32'd0);
    check("rst_taken", 32'(pred_taken), 32'd0);
    check("rst_ctr", 32'(pred_ctr), 32'd0);
    check("rst_hidx", 32'(pred_hidx), 32'd0);
    reset = 0; pred_valid = 0; upd_valid = 0;
    model_reset();
  endtask

  initial begin
    reset = 1; pred_valid = 0; pred_index = '0; upd_valid = 0; upd_index = '0; upd_taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Reset contents: every entry weakly not-taken.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, i, 0, 0, 0);
      check("init_ctr", 32'(pred_ctr), 32'd1);
    end

    // Saturate high at index 3 (updates via unhashed index).
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 3, 1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 3, 1);
    cycle(0, 0, 0, 0, 0);
    ghr_m = ghr_m; // history now shifted by three taken outcomes in gshare builds
    cycle(1, model_hash(3) ^ 0 ^ 0, 0, 0, 0);

    // Saturate low at index 5.
    do_reset();
    cycle(0, 0, 1, 5, 0);
    cycle(0, 0, 1, 5, 0);
    cycle(1, model_hash(5) == 5 ? 5 : (5 ^ ghr_m), 0, 0, 0);
    check("idx5_floor", 32'(pred_ctr), 32'd0);

    // Same-cycle forwarding at 7, no forwarding for a different index.
    do_reset();
    cycle(1, 7, 1, 7, 1);
    check("fwd_ctr", 32'(pred_ctr), 32'd2);
    cycle(1, 8, 0, 0, 0);
    check("nofwd_ctr", 32'(pred_ctr), 32'd1);

    // Reset wins over concurrent predict/update after driving entries to 11.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 1, i, 1);
      cycle(0, 0, 1, i, 1);
    end
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, i, 0, 0, 0);

    // History hashing: two taken updates then predict 5.
    do_reset();
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(1, 5, 0, 0, 0);
`ifdef PHT_GSHARE_EN
    check("hash_hidx", 32'(pred_hidx), 32'h6);
`else
    check("hash_hidx", 32'(pred_hidx), 32'h5);
`endif
    check("hash_ctr", 32'(pred_ctr), 32'd1);

    // Random mix of predicts and updates.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
            1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)));

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
